// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer.
//   sel_width()   : select-field width for a channel count (never below 1)
//   DefaultDataW  : default payload width
//   DefaultCntW   : default drop-counter width
//   DefaultCntMax : saturation value of a default-width drop counter
//   slot_state_e  : occupancy state of a one-entry channel slot
package demux_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultCntW  = 8;
  localparam logic [DefaultCntW-1:0] DefaultCntMax = '1;

  typedef enum logic {
    SlotEmpty = 1'b0,
    SlotFull  = 1'b1
  } slot_state_e;

  // $clog2(2) is 1 but $clog2(1) is 0; a select port must be at least one bit wide.
  function automatic int unsigned sel_width(int unsigned num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : write data_i this cycle (only asserted when ch_rdy_o is high)
//   data_i       : payload to load
//   out_ready_i  : consumer ready
//   ch_rdy_o     : slot can take a beat this cycle (empty, or draining now)
//   out_valid_o  : slot holds a beat
//   out_data_o   : held payload, stable while stalled
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              out_ready_i,
  output logic              ch_rdy_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SlotEmpty: if (load_i) state_d = SlotFull;
      SlotFull:  if (out_ready_i && !load_i) state_d = SlotEmpty;
    endcase
    if (load_i) data_d = data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SlotEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Ready while draining lets a new beat follow with no bubble.
  assign ch_rdy_o    = (state_q == SlotEmpty) || out_ready_i;
  assign out_valid_o = (state_q == SlotFull);
  assign out_data_o  = data_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-NUM_CH stream demultiplexer with broadcast and drop counting.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid_i     : input beat present
//   in_ready_o     : beat accepted this cycle (independent of in_valid_i)
//   in_data_i      : input payload
//   in_sel_i       : destination channel; values >= NUM_CH are discarded
//   in_bcast_i     : write all channels at once (all-or-nothing), in_sel_i ignored
//   out_valid_o    : per-channel valid
//   out_ready_i    : per-channel consumer ready
//   out_data_o     : channel c payload at [c*DATA_W +: DATA_W]
//   drop_pulse_o   : one-cycle pulse the cycle after a beat is discarded
//   drop_count_o   : saturating count of discarded beats
module stream_demux_n
  import demux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned SEL_W  = sel_width(NUM_CH),
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic [SEL_W-1:0]         in_sel_i,
  input  logic                     in_bcast_i,
  output logic [NUM_CH-1:0]        out_valid_o,
  input  logic [NUM_CH-1:0]        out_ready_i,
  output logic [NUM_CH*DATA_W-1:0] out_data_o,
  output logic                     drop_pulse_o,
  output logic [CNT_W-1:0]         drop_count_o
);

  localparam logic [SEL_W:0]   NumChExt = (SEL_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic [NUM_CH-1:0] ch_rdy;
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] load;
  logic              sel_in_range;
  logic              drop;
  logic              drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  assign sel_in_range = ({1'b0, in_sel_i} < NumChExt);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sel_oh[c] = (in_sel_i == SEL_W'(c));
    end
  end

  always_comb begin
    in_ready_o = 1'b0;
    load       = '0;
    drop       = 1'b0;
    if (in_bcast_i) begin
      in_ready_o = &ch_rdy;
      load       = {NUM_CH{in_valid_i && (&ch_rdy)}};
    end else if (sel_in_range) begin
      in_ready_o = |(sel_oh & ch_rdy);
      load       = sel_oh & ch_rdy & {NUM_CH{in_valid_i}};
    end else begin
      // Out-of-range destination: swallow the beat so the producer never stalls.
      in_ready_o = 1'b1;
      drop       = in_valid_i;
    end
  end

  always_comb begin
    drop_pulse_d = drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != CntMax)) drop_count_d = drop_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_pulse_o = drop_pulse_q;
  assign drop_count_o = drop_count_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load[c]),
      .data_i     (in_data_i),
      .out_ready_i(out_ready_i[c]),
      .ch_rdy_o   (ch_rdy[c]),
      .out_valid_o(out_valid_o[c]),
      .out_data_o (out_data_o[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised 1-to-N stream demultiplexer. It is the registered, handshaked successor to the team's combinational 1x2 demux.
- Routes one input stream to one of NUM_CH output channels selected by in_sel. An optional broadcast mode sends the same beat to all channels.
- Each channel owns a one-entry output register with valid/ready handshake. Upstream stalls only on the selected channel.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- NUM_CH, 4: number of output channels, 2..16.
- DATA_W, 8: payload width in bits.
- SEL_W, $clog2(NUM_CH) (minimum 1): width of in_sel.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat this cycle.
- in_data  input  DATA_W  input payload.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  broadcast beat to all channels; in_sel is ignored.
- out_valid  output  NUM_CH  per-channel data valid.
- out_ready  input  NUM_CH  per-channel consumer ready.
- out_data  output  NUM_CH*DATA_W  channel c payload in bits [c*DATA_W +: DATA_W].
- drop_pulse  output  1  one-cycle pulse when a beat is discarded.
- drop_count  output  CNT_W  saturating count of discarded beats.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid = 0, out_data = 0, drop_pulse = 0, drop_count = 0. in_ready is combinational and goes high immediately after reset.
- Reset mid-operation: all buffered beats are lost and out_valid clears asynchronously. The counter clears.
- Channel-ready term: ch_rdy[c] = ~out_valid[c] | out_ready[c]. A channel can accept a new beat in the same cycle its current beat drains.
- Unicast (in_bcast = 0), in_sel < NUM_CH: in_ready = ch_rdy[in_sel].
- Unicast, in_sel >= NUM_CH: in_ready = 1. The beat is accepted and discarded. drop_pulse = 1 on the next cycle and drop_count increments.
- Broadcast (in_bcast = 1): in_ready = &ch_rdy. This is all-or-nothing: no partial writes ever occur.
- Transfer occurs on the clock edge where in_valid & in_ready = 1.
- On transfer, each target channel loads in_data and sets out_valid[c] = 1 on the next cycle. Latency is one cycle from input accept to out_valid.
- Consumer side: out_valid[c] & out_ready[c] completes the beat. The channel clears out_valid[c] unless it is reloaded in that same cycle.
- Holding: while out_valid[c] = 1 and out_ready[c] = 0, out_data[c] is held stable.
- Non-target channels are unaffected by a transfer. Their out_valid and out_data hold or drain independently.
- in_ready must not depend on in_valid. It may depend on in_sel, in_bcast and out_ready.
- Throughput: one beat per cycle sustained to any channel whose consumer holds out_ready = 1.
- drop_count saturates at 2^CNT_W-1. It does not wrap, and drop_pulse still asserts when saturated.
- Non-power-of-two NUM_CH: sel values NUM_CH..2^SEL_W-1 are the drop range.
- No internal state machine beyond the per-channel full flag. Each slot has two states, EMPTY and FULL.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without reload.
  - FULL -> FULL on drain with reload, or on stall.

Decomposition:
- Shared package (demux_pkg):
  - clog2-based localparam helper for SEL_W.
  - DATA_W default constant.
  - Counter-saturation max constant.
- One sub-module, demux_slot: one-entry register holding valid flag and data, with load, out_ready and ch_rdy ports. It is instantiated NUM_CH times via generate.
- Top level holds the select decode, broadcast AND-reduce, drop detection and counter.

Test Plan (NUM_CH=4, DATA_W=8, CNT_W=8):
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=4'b0000, drop_count=0. Release rst_n; next edge with sel=2, data=0xA5 -> out_valid=4'b0100 and ch2 data 0xA5 one cycle later.
- Back-pressure: fill ch1 with 0x11 while out_ready[1]=0, then offer 0x22 to ch1 -> in_ready=0 and ch1 holds 0x11. Raise out_ready[1] -> same-cycle drain and reload, ch1 shows 0x22 with no bubble.
- Independence: ch0 stalled and full; send 0x33 to ch3 -> accepted, ch3 out_valid=1, ch0 data unchanged.
- Broadcast: in_bcast=1, data=0x5A, all channels empty -> all four out_valid=1 with data 0x5A. Repeat with ch2 stalled and full -> in_ready=0 and no channel is written.
- Drop: run with NUM_CH=3. Send sel=3 -> in_ready=1, drop_pulse one cycle, drop_count=1, no out_valid change. Force 300 drops -> drop_count=255 (saturated).
- Streaming: ch0 with out_ready=1 and 16 back-to-back beats 0x00..0x0F -> 16 outputs in order on consecutive cycles, no gaps.
